// File: rtl/buffer_parity_checker.sv
// buffer_parity_checker
// Serial parity and duplex-compare stage that sits after the A/B buffer
// registers. It walks one memory syllable bit-serially from both channels.
// It checks each channel's parity and compares the two streams bit for bit.
// It keeps per-word error flags and a saturating count of erroneous words.

module buffer_parity_checker #(
    parameter int NBITS = 13,
    parameter bit ODD   = 1'b1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic       bit_strobe,
    input  logic       bra_ser,
    input  logic       brb_ser,
    input  logic       bra_par,
    input  logic       brb_par,
    input  logic       clr_cnt,
    output logic       busy,
    output logic       done,
    output logic       perr_a,
    output logic       perr_b,
    output logic       miscmp,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Index of the final data bit. Reaching it moves the word into CHECK.
    localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);
    localparam logic [3:0] CNT_MAX  = 4'd15;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pa_q, pa_d;
    logic       pb_q, pb_d;
    logic       mm_q, mm_d;
    logic       perr_a_q, perr_a_d;
    logic       perr_b_q, perr_b_d;
    logic       miscmp_q, miscmp_d;
    logic [3:0] err_cnt_q, err_cnt_d;

    logic       perr_a_new;
    logic       perr_b_new;
    logic       miscmp_new;
    logic       word_err;

    // Evaluate the finished word from the accumulators and the live parity bits.
    always_comb begin
        perr_a_new = ((pa_q ^ bra_par) != ODD);
        perr_b_new = ((pb_q ^ brb_par) != ODD);
        miscmp_new = mm_q | (bra_par != brb_par);
        word_err   = perr_a_new | perr_b_new | miscmp_new;
    end

    // Sequencing of a syllable: restart, bit accumulation and the single CHECK cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        mm_d    = mm_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    pa_d    = 1'b0;
                    pb_d    = 1'b0;
                    mm_d    = 1'b0;
                end
            end

            SHIFT: begin
                if (start) begin
                    // A new start abandons the partial word, including any strobe data this cycle.
                    cnt_d = '0;
                    pa_d  = 1'b0;
                    pb_d  = 1'b0;
                    mm_d  = 1'b0;
                end else if (bit_strobe) begin
                    pa_d  = pa_q ^ bra_ser;
                    pb_d  = pb_q ^ brb_ser;
                    mm_d  = mm_q | (bra_ser != brb_ser);
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = CHECK;
                    end
                end
            end

            CHECK: begin
                if (start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    pa_d    = 1'b0;
                    pb_d    = 1'b0;
                    mm_d    = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Result flags are captured only when a word is checked and held otherwise.
    always_comb begin
        perr_a_d = perr_a_q;
        perr_b_d = perr_b_q;
        miscmp_d = miscmp_q;
        if (state_q == CHECK) begin
            perr_a_d = perr_a_new;
            perr_b_d = perr_b_new;
            miscmp_d = miscmp_new;
        end
    end

    // Error counter saturates at 15. A clear overrides a simultaneous increment.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_cnt) begin
            err_cnt_d = '0;
        end else if ((state_q == CHECK) && word_err && (err_cnt_q != CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    // State, accumulators and results. Reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pa_q      <= 1'b0;
            pb_q      <= 1'b0;
            mm_q      <= 1'b0;
            perr_a_q  <= 1'b0;
            perr_b_q  <= 1'b0;
            miscmp_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pa_q      <= pa_d;
            pb_q      <= pb_d;
            mm_q      <= mm_d;
            perr_a_q  <= perr_a_d;
            perr_b_q  <= perr_b_d;
            miscmp_q  <= miscmp_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // The flags show the fresh verdict during the CHECK cycle, alongside done.
    // After that they show the captured value until the next check.
    always_comb begin
        busy    = (state_q != IDLE);
        done    = (state_q == CHECK);
        perr_a  = (state_q == CHECK) ? perr_a_new : perr_a_q;
        perr_b  = (state_q == CHECK) ? perr_b_new : perr_b_q;
        miscmp  = (state_q == CHECK) ? miscmp_new : miscmp_q;
        err_cnt = err_cnt_q;
    end

endmodule

// File: tb/tb_buffer_parity_checker.sv
// tb_buffer_parity_checker
// Directed and randomized words for buffer_parity_checker.
// Expected flags and counts come from whole-word parity and equality arithmetic.

module tb_buffer_parity_checker;

    localparam int NBITS = 13;
    localparam bit ODD   = 1'b1;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic       bit_strobe;
    logic       bra_ser;
    logic       brb_ser;
    logic       bra_par;
    logic       brb_par;
    logic       clr_cnt;
    logic       busy;
    logic       done;
    logic       perr_a;
    logic       perr_b;
    logic       miscmp;
    logic [3:0] err_cnt;

    int total = 0;
    int bad   = 0;

    int   expCnt = 0;
    logic expPa  = 1'b0;
    logic expPb  = 1'b0;
    logic expMm  = 1'b0;

    buffer_parity_checker #(.NBITS(NBITS), .ODD(ODD)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .bit_strobe (bit_strobe),
        .bra_ser    (bra_ser),
        .brb_ser    (brb_ser),
        .bra_par    (bra_par),
        .brb_par    (brb_par),
        .clr_cnt    (clr_cnt),
        .busy       (busy),
        .done       (done),
        .perr_a     (perr_a),
        .perr_b     (perr_b),
        .miscmp     (miscmp),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, ".perr_a"}, {3'b0, perr_a}, {3'b0, expPa});
        checkOutput({tag, ".perr_b"}, {3'b0, perr_b}, {3'b0, expPb});
        checkOutput({tag, ".miscmp"}, {3'b0, miscmp}, {3'b0, expMm});
        checkOutput({tag, ".err_cnt"}, err_cnt, 4'(expCnt));
    endtask

    // Start a word, feed a few strobes, then pull reset. The word must vanish without done.
    task automatic resetMidShift(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bra_ser    = 1'($urandom);
            brb_ser    = 1'($urandom);
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
        end
        checkOutput({tag, ".busyBefore"}, {3'b0, busy}, 4'd1);
        rstn = 1'b0;
        tick();
        rstn   = 1'b1;
        expCnt = 0;
        expPa  = 1'b0;
        expPb  = 1'b0;
        expMm  = 1'b0;
        checkOutput({tag, ".busy"}, {3'b0, busy}, 4'd0);
        checkOutput({tag, ".done"}, {3'b0, done}, 4'd0);
        checkFlags(tag);
        for (int i = 0; i < 3; i++) begin
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            checkOutput({tag, ".idleDone"}, {3'b0, done}, 4'd0);
            checkOutput({tag, ".idleBusy"}, {3'b0, busy}, 4'd0);
        end
    endtask

    // Shift one word LSB-first with random strobe gaps, then check the CHECK cycle and its aftermath.
    task automatic applyStimulus(input logic [14:0] a, input logic [14:0] b,
                                 input logic pa, input logic pb,
                                 input bit startFirst, input bit startInCheck,
                                 input bit clrInCheck);
        int onesA;
        int onesB;
        int gap;
        logic anyErr;
        if (startFirst) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            checkOutput("startBusy", {3'b0, busy}, 4'd1);
            checkOutput("startNoDone", {3'b0, done}, 4'd0);
        end
        for (int i = 0; i < NBITS; i++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                bra_ser = 1'($urandom);
                brb_ser = 1'($urandom);
                tick();
            end
            bra_ser    = a[i];
            brb_ser    = b[i];
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            if (i < NBITS - 1) begin
                checkOutput("shiftNoDone", {3'b0, done}, 4'd0);
            end
        end

        bra_par    = pa;
        brb_par    = pb;
        start      = startInCheck;
        clr_cnt    = clrInCheck;
        bit_strobe = 1'b1;
        bra_ser    = 1'($urandom);
        brb_ser    = ~bra_ser;

        onesA  = $countones(a[NBITS-1:0]);
        onesB  = $countones(b[NBITS-1:0]);
        expPa  = (((onesA + int'(pa)) % 2) != int'(ODD));
        expPb  = (((onesB + int'(pb)) % 2) != int'(ODD));
        expMm  = (a[NBITS-1:0] != b[NBITS-1:0]) || (pa != pb);
        anyErr = expPa | expPb | expMm;
        #1;
        checkOutput("checkDone", {3'b0, done}, 4'd1);
        checkOutput("checkBusy", {3'b0, busy}, 4'd1);
        checkOutput("checkPerrA", {3'b0, perr_a}, {3'b0, expPa});
        checkOutput("checkPerrB", {3'b0, perr_b}, {3'b0, expPb});
        checkOutput("checkMiscmp", {3'b0, miscmp}, {3'b0, expMm});

        if (clrInCheck) begin
            expCnt = 0;
        end else if (anyErr && expCnt < 15) begin
            expCnt = expCnt + 1;
        end

        tick();
        start      = 1'b0;
        clr_cnt    = 1'b0;
        bit_strobe = 1'b0;
        checkOutput("doneOnce", {3'b0, done}, 4'd0);
        checkOutput("afterBusy", {3'b0, busy}, {3'b0, startInCheck});
        checkFlags("after");
        bra_par = 1'($urandom);
        brb_par = 1'($urandom);
    endtask

    initial begin
        logic [14:0] ra;
        logic [14:0] rb;
        bit chain;
        bit nextChain;

        rstn       = 1'b0;
        start      = 1'b0;
        bit_strobe = 1'b0;
        bra_ser    = 1'b0;
        brb_ser    = 1'b0;
        bra_par    = 1'b0;
        brb_par    = 1'b0;
        clr_cnt    = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        checkOutput("rst.busy", {3'b0, busy}, 4'd0);
        checkOutput("rst.done", {3'b0, done}, 4'd0);
        checkFlags("rst");

        resetMidShift("midReset1");

        $display("[TB] clean word");
        applyStimulus(15'h0A5, 15'h0A5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] parity error on B");
        applyStimulus(15'h0A5, 15'h0A5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] data mismatch");
        applyStimulus(15'h0A5, 15'h0A4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] restart and back-to-back");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bra_ser    = 1'b1;
            brb_ser    = 1'b0;
            bit_strobe = 1'b1;
            tick();
            bit_strobe = 1'b0;
            checkOutput("restartNoDone", {3'b0, done}, 4'd0);
        end
        bra_ser    = 1'b1;
        brb_ser    = 1'b0;
        bit_strobe = 1'b1;
        applyStimulus(15'h0A5, 15'h0A5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(15'h1234, 15'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random words");
        chain = 1'b0;
        for (int k = 0; k < 12; k++) begin
            ra = 15'($urandom);
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = ra ^ (15'd1 << $urandom_range(0, NBITS - 1));
                default: rb = 15'($urandom);
            endcase
            nextChain = (k < 11) ? 1'($urandom) : 1'b0;
            applyStimulus(ra, rb, 1'($urandom), 1'($urandom), !chain, nextChain, 1'b0);
            chain = nextChain;
        end

        resetMidShift("midReset2");

        $display("[TB] saturation");
        for (int k = 0; k < 17; k++) begin
            ra = 15'($urandom);
            applyStimulus(ra, ~ra, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("saturated", err_cnt, 4'd15);

        $display("[TB] clear during erroring check");
        applyStimulus(15'h0A5, 15'h0A5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("clearWins", err_cnt, 4'd0);
        tick();
        checkFlags("idleHold");

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
